photon_ise_arb: RTL and testbench

- Two-requester arbiter and sequencer for the shared PHOTON step ISE datapath (the xalu_ise instance).
- Requester A is the core execute stage; requester B is the permutation sequencer/coprocessor.
- Accepts one request at a time, drives the ISE for one cycle, registers the result, and returns it with a valid/ready response handshake to the granted requester.
- Requests the ISE does not claim (unsupported funct/fn) complete with an error flag and zero data, so they never hang.

---
 rtl/photon_ise_arb_if.sv | 28 ++
 rtl/photon_ise_arb.sv | 115 +++++++++++
 tb/tb_photon_ise_arb.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/photon_ise_arb_if.sv
// Requester-side request/response bundle for the PHOTON step ISE arbiter.
// master = requester (core execute stage or permutation sequencer), slave = arbiter.
interface photon_ise_arb_if;
    localparam int unsigned FN_W   = 6;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned DATA_W = 32;

    logic              req_val;
    logic              req_rdy;
    logic [FN_W-1:0]   fn;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              rsp_val;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_val, fn, imm, in1, in2, rsp_rdy,
        input  req_rdy, rsp_val, rsp_data, rsp_err
    );

    modport slave (
        input  req_val, fn, imm, in1, in2, rsp_rdy,
        output req_rdy, rsp_val, rsp_data, rsp_err
    );
endinterface

// File: rtl/photon_ise_arb.sv
// Two-requester arbiter/sequencer for the shared PHOTON step ISE: one request in flight,
// one ISE cycle per request, registered result returned on a valid/ready response.
module photon_ise_arb #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter bit RR_INIT    = 1'b0
) (
    input  logic                ise_clk,
    input  logic                ise_rst,
    photon_ise_arb_if.slave     a,
    photon_ise_arb_if.slave     b,
    output logic [5:0]          x_fn,
    output logic [6:0]          x_imm,
    output logic [31:0]         x_in1,
    output logic [31:0]         x_in2,
    output logic                x_val,
    input  logic                x_oval,
    input  logic [31:0]         x_out
);
    localparam int unsigned FN_W   = 6;
    localparam int unsigned IMM_W  = 7;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic                owner_q;
    logic [FN_W-1:0]     fn_q;
    logic [IMM_W-1:0]    imm_q;
    logic [DATA_W-1:0]   in1_q;
    logic [DATA_W-1:0]   in2_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                grant_a;
    logic                grant_b;

    // Next-state, arbitration and rr update; rr = 1 means B is preferred on a collision.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a.req_val && (!b.req_val || FIXED_PRIO || !rr_q)) begin
                    grant_a = 1'b1;
                end else if (b.req_val) begin
                    grant_b = 1'b1;
                end
                if (grant_a || grant_b) begin
                    state_d = ISSUE;
                    if (!FIXED_PRIO) begin
                        rr_d = grant_a;
                    end
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                if (owner_q ? b.rsp_rdy : a.rsp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state_q <= IDLE;
            rr_q    <= RR_INIT;
            owner_q <= 1'b0;
            fn_q    <= '0;
            imm_q   <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (grant_a || grant_b) begin
                owner_q <= grant_b;
                fn_q    <= grant_b ? b.fn  : a.fn;
                imm_q   <= grant_b ? b.imm : a.imm;
                in1_q   <= grant_b ? b.in1 : a.in1;
                in2_q   <= grant_b ? b.in2 : a.in2;
            end
            // Unclaimed requests complete with zero data and the error flag.
            if (state_q == ISSUE) begin
                data_q <= x_oval ? x_out : DATA_W'(0);
                err_q  <= ~x_oval;
            end
        end
    end

    // req_rdy is gated by reset so both requesters see 0 while reset is held.
    assign a.req_rdy  = grant_a && !ise_rst;
    assign b.req_rdy  = grant_b && !ise_rst;
    assign a.rsp_val  = (state_q == RESP) && !owner_q;
    assign b.rsp_val  = (state_q == RESP) &&  owner_q;
    assign a.rsp_data = data_q;
    assign b.rsp_data = data_q;
    assign a.rsp_err  = err_q;
    assign b.rsp_err  = err_q;

    assign x_val = (state_q == ISSUE);
    assign x_fn  = fn_q;
    assign x_imm = imm_q;
    assign x_in1 = in1_q;
    assign x_in2 = in2_q;
endmodule

// File: tb/tb_photon_ise_arb.sv
// Self-checking bench for photon_ise_arb: directed scenarios plus random traffic checked
// against a transaction-level reference model, and a fixed-priority instance.
module tb_photon_ise_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    photon_ise_arb_if ia ();
    photon_ise_arb_if ib ();
    photon_ise_arb_if fa ();
    photon_ise_arb_if fb ();

    logic [5:0]  x_fn,  f_fn;
    logic [6:0]  x_imm, f_imm;
    logic [31:0] x_in1, x_in2, f_in1, f_in2;
    logic        x_val, f_val;
    logic        x_oval, f_oval;
    logic [31:0] x_out, f_out;

    int n_checks = 0;
    int n_errors = 0;

    // Stand-in ISE: claims fn[1:0]!=0 with imm[6:3]==0; garbage on x_out when not claiming.
    function automatic bit ise_claim(input logic [5:0] fn, input logic [6:0] imm);
        return (fn[1:0] != 2'b00) && (imm[6:3] == 4'h0);
    endfunction

    function automatic logic [31:0] ise_calc(input logic [5:0] fn, input logic [6:0] imm,
                                             input logic [31:0] in1, input logic [31:0] in2);
        case (fn[1:0])
            2'd1:    return in1 ^ (in2 << imm[2:0]);
            2'd2:    return in1 + in2 + 32'(imm);
            2'd3:    return ~(in1 & in2) ^ 32'(fn);
            default: return 32'h0;
        endcase
    endfunction

    assign x_oval = x_val && ise_claim(x_fn, x_imm);
    assign x_out  = x_oval ? ise_calc(x_fn, x_imm, x_in1, x_in2) : 32'hDEAD_BEEF;
    assign f_oval = f_val && ise_claim(f_fn, f_imm);
    assign f_out  = f_oval ? ise_calc(f_fn, f_imm, f_in1, f_in2) : 32'hDEAD_BEEF;

    photon_ise_arb #(.FIXED_PRIO(1'b0), .RR_INIT(1'b0)) u_dut (
        .ise_clk(clk), .ise_rst(rst), .a(ia), .b(ib),
        .x_fn(x_fn), .x_imm(x_imm), .x_in1(x_in1), .x_in2(x_in2),
        .x_val(x_val), .x_oval(x_oval), .x_out(x_out)
    );

    photon_ise_arb #(.FIXED_PRIO(1'b1), .RR_INIT(1'b1)) u_fp (
        .ise_clk(clk), .ise_rst(rst), .a(fa), .b(fb),
        .x_fn(f_fn), .x_imm(f_imm), .x_in1(f_in1), .x_in2(f_in2),
        .x_val(f_val), .x_oval(f_oval), .x_out(f_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Fixed-priority instance: both requesters always valid, every grant counted.
    int fp_a = 0;
    int fp_b = 0;
    always @(negedge clk) begin
        if (fa.req_val && fa.req_rdy) fp_a++;
        if (fb.req_val && fb.req_rdy) fp_b++;
    end

    // Reference model: one outstanding transaction, aged in cycles since accept.
    bit          busy = 1'b0;
    int          age = 0;
    bit          own = 1'b0;
    bit          pref_b = 1'b0;
    logic [5:0]  e_fn = '0;
    logic [6:0]  e_imm = '0;
    logic [31:0] e_in1 = '0, e_in2 = '0, e_data = '0;
    bit          e_err = 1'b0;
    bit          acc_a = 1'b0, acc_b = 1'b0, done = 1'b0;
    logic [5:0]  p_fn;
    logic [6:0]  p_imm;
    logic [31:0] p_in1, p_in2;
    int          cyc = 0;
    int          g_cyc[$];
    bit          g_own[$];

    task automatic check_cycle();
        bit wa, wb;
        wa = 1'b0;
        wb = 1'b0;
        done = 1'b0;
        if (!busy) begin
            if (ia.req_val && ib.req_val) begin
                wa = !pref_b;
                wb = pref_b;
            end else begin
                wa = ia.req_val;
                wb = ib.req_val;
            end
        end
        chk("a_req_rdy", 32'(ia.req_rdy), 32'(wa));
        chk("b_req_rdy", 32'(ib.req_rdy), 32'(wb));
        chk("x_val", 32'(x_val), 32'(busy && age == 0));
        chk("a_rsp_val", 32'(ia.rsp_val), 32'(busy && age > 0 && !own));
        chk("b_rsp_val", 32'(ib.rsp_val), 32'(busy && age > 0 && own));
        chk("x_fn", 32'(x_fn), 32'(e_fn));
        chk("x_imm", 32'(x_imm), 32'(e_imm));
        chk("x_in1", x_in1, e_in1);
        chk("x_in2", x_in2, e_in2);
        if (busy && age > 0) begin
            chk("a_rsp_data", ia.rsp_data, e_data);
            chk("b_rsp_data", ib.rsp_data, e_data);
            chk("a_rsp_err", 32'(ia.rsp_err), 32'(e_err));
            chk("b_rsp_err", 32'(ib.rsp_err), 32'(e_err));
            done = own ? ib.rsp_rdy : ia.rsp_rdy;
        end
        if (ia.req_val && ia.req_rdy) begin g_cyc.push_back(cyc); g_own.push_back(1'b0); end
        if (ib.req_val && ib.req_rdy) begin g_cyc.push_back(cyc); g_own.push_back(1'b1); end
        acc_a = wa;
        acc_b = wb;
        if (wb) begin p_fn = ib.fn; p_imm = ib.imm; p_in1 = ib.in1; p_in2 = ib.in2; end
        else    begin p_fn = ia.fn; p_imm = ia.imm; p_in1 = ia.in1; p_in2 = ia.in2; end
    endtask

    task automatic model_update();
        if (acc_a || acc_b) begin
            busy   = 1'b1;
            age    = 0;
            own    = acc_b;
            pref_b = acc_a;
            e_fn   = p_fn;
            e_imm  = p_imm;
            e_in1  = p_in1;
            e_in2  = p_in2;
            e_err  = !ise_claim(p_fn, p_imm);
            e_data = e_err ? 32'h0 : ise_calc(p_fn, p_imm, p_in1, p_in2);
        end else if (busy) begin
            if (age > 0 && done) busy = 1'b0;
            else age++;
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        model_update();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle and checks outputs drop at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_a_rsp_val", 32'(ia.rsp_val), 32'h0);
        chk("rst_b_rsp_val", 32'(ib.rsp_val), 32'h0);
        chk("rst_a_req_rdy", 32'(ia.req_rdy), 32'h0);
        chk("rst_b_req_rdy", 32'(ib.req_rdy), 32'h0);
        chk("rst_x_val", 32'(x_val), 32'h0);
        chk("rst_rsp_data", ia.rsp_data, 32'h0);
        chk("rst_rsp_err", 32'(ia.rsp_err), 32'h0);
        chk("rst_x_in1", x_in1, 32'h0);
        busy = 1'b0; age = 0; pref_b = 1'b0;
        acc_a = 1'b0; acc_b = 1'b0; done = 1'b0;
        e_fn = '0; e_imm = '0; e_in1 = '0; e_in2 = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drv(input bit sel_b, input bit v, input logic [5:0] fn, input logic [6:0] imm,
                       input logic [31:0] in1, input logic [31:0] in2);
        if (sel_b) begin
            ib.req_val = v; ib.fn = fn; ib.imm = imm; ib.in1 = in1; ib.in2 = in2;
        end else begin
            ia.req_val = v; ia.fn = fn; ia.imm = imm; ia.in1 = in1; ia.in2 = in2;
        end
    endtask

    task automatic rand_drive();
        for (int s = 0; s < 2; s++) begin
            bit cur, acc;
            logic [6:0] imm;
            cur = (s == 1) ? ib.req_val : ia.req_val;
            acc = (s == 1) ? acc_b : acc_a;
            if (cur && !acc) begin
                if ($urandom_range(7) == 0) begin
                    if (s == 1) ib.req_val = 1'b0; else ia.req_val = 1'b0;
                end
            end else begin
                imm = ($urandom_range(1) == 1) ? 7'($urandom_range(7)) : 7'($urandom);
                drv(s == 1, 1'($urandom_range(1)), 6'($urandom), imm, $urandom, $urandom);
            end
        end
        ia.rsp_rdy = ($urandom_range(2) != 0);
        ib.rsp_rdy = ($urandom_range(2) != 0);
    endtask

    initial begin
        drv(1'b0, 1'b0, '0, '0, '0, '0);
        drv(1'b1, 1'b0, '0, '0, '0, '0);
        ia.rsp_rdy = 1'b1;
        ib.rsp_rdy = 1'b1;
        fa.req_val = 1'b1; fa.fn = 6'h01; fa.imm = 7'h01; fa.in1 = 32'h1; fa.in2 = 32'h2; fa.rsp_rdy = 1'b1;
        fb.req_val = 1'b1; fb.fn = 6'h02; fb.imm = 7'h02; fb.in1 = 32'h3; fb.in2 = 32'h4; fb.rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Claimed A request: accept, one ISE cycle, response.
        drv(1'b0, 1'b1, 6'b000010, 7'h03, 32'h0123_4567, 32'h89AB_CDEF);
        step();
        ia.req_val = 1'b0;
        step();
        chk("t1_a_rsp_data", ia.rsp_data, 32'h8ACF_1359);
        chk("t1_a_rsp_err", 32'(ia.rsp_err), 32'h0);
        step();
        step();

        // Unclaimed requests: high funct bits, then fn[1:0]=0.
        drv(1'b0, 1'b1, 6'b000010, 7'h08, 32'h1111_1111, 32'h2222_2222);
        step();
        ia.req_val = 1'b0;
        step();
        chk("t2_err_imm", 32'(ia.rsp_err), 32'h1);
        chk("t2_data_imm", ia.rsp_data, 32'h0);
        step();
        drv(1'b0, 1'b1, 6'b111100, 7'h01, 32'h3333_3333, 32'h4444_4444);
        repeat (3) step();
        ia.req_val = 1'b0;
        step();

        // Both valid every cycle: round-robin alternation, 3 cycles between accepts.
        do_reset();
        drv(1'b0, 1'b1, 6'h01, 7'h02, 32'hA5A5_0001, 32'h0F0F_0002);
        drv(1'b1, 1'b1, 6'h03, 7'h05, 32'h5A5A_0003, 32'hF0F0_0004);
        g_cyc.delete();
        g_own.delete();
        repeat (24) step();
        chk("rr_grant_count", 32'(g_own.size() >= 8), 32'h1);
        for (int i = 0; i < 8 && i < g_own.size(); i++) begin
            chk("rr_owner", 32'(g_own[i]), 32'(i % 2));
            if (i > 0) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end

        // B owns the ISE and stalls its response for 5 cycles while A waits.
        ia.req_val = 1'b0;
        ib.req_val = 1'b0;
        repeat (3) step();
        drv(1'b1, 1'b1, 6'h02, 7'h04, 32'h0000_1000, 32'h0000_0234);
        ib.rsp_rdy = 1'b0;
        step();
        ib.req_val = 1'b0;
        drv(1'b0, 1'b1, 6'h01, 7'h01, 32'hCAFE_0000, 32'h0000_BEEF);
        repeat (6) step();
        ib.rsp_rdy = 1'b1;
        step();
        step();
        chk("hold_a_granted", 32'(x_val), 32'h1);
        ia.req_val = 1'b0;
        repeat (3) step();

        // Reset during ISSUE; afterwards rr is back at its reset value.
        drv(1'b0, 1'b1, 6'h03, 7'h00, 32'h1234_0000, 32'h0000_5678);
        step();
        do_reset();
        ib.req_val = 1'b1;
        step();
        ia.req_val = 1'b0;
        ib.req_val = 1'b0;
        repeat (3) step();

        // Reset during RESP with the response stalled.
        drv(1'b1, 1'b1, 6'h01, 7'h03, 32'h0BAD_F00D, 32'h0000_0011);
        ib.rsp_rdy = 1'b0;
        step();
        ib.req_val = 1'b0;
        step();
        step();
        do_reset();
        ib.rsp_rdy = 1'b1;
        drv(1'b0, 1'b1, 6'h02, 7'h07, 32'h0000_0100, 32'h0000_0200);
        step();
        ia.req_val = 1'b0;
        repeat (3) step();

        // B pulses req_val while A sits in RESP; nothing may be granted to B.
        drv(1'b0, 1'b1, 6'h01, 7'h02, 32'h7777_0000, 32'h0000_0003);
        ia.rsp_rdy = 1'b0;
        step();
        ia.req_val = 1'b0;
        step();
        drv(1'b1, 1'b1, 6'h02, 7'h01, 32'h0000_0009, 32'h0000_0009);
        step();
        ib.req_val = 1'b0;
        step();
        ia.rsp_rdy = 1'b1;
        repeat (4) step();

        // Random traffic against the reference model.
        repeat (3000) begin
            rand_drive();
            step();
        end

        chk("fp_b_grants", 32'(fp_b), 32'h0);
        chk("fp_a_grants_min", 32'(fp_a >= 8), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
